// File: rtl/padder_rate.sv
// padder_rate
//   Multi-rate, multi-message padder in front of the Keccak f-permutation.
//   Packs 64-bit user words into RATE_WORDS-word blocks, appends DSBYTE
//   after the last data byte and sets 0x80 in the last byte of the final
//   block. It re-arms after the final block is acknowledged, so
//   back-to-back messages need no reset.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   in           user word, byte 0 = in[63:56]
//   in_ready     in is valid (accepted when buffer_full = 0)
//   is_last      in is the final word of the message
//   byte_num     valid bytes in the final word (0..7)
//   buffer_full  block is not accepting user input
//   out          assembled block, first word in the MSBs
//   out_ready    out holds a complete block
//   out_last     the block in out is the final block of its message
//   f_ack        permutation has consumed out
module padder_rate #(
    parameter int         RATE_WORDS = 9,
    parameter logic [7:0] DSBYTE     = 8'h01
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              in,
    input  logic                     in_ready,
    input  logic                     is_last,
    input  logic [2:0]               byte_num,
    output logic                     buffer_full,
    output logic [RATE_WORDS*64-1:0] out,
    output logic                     out_ready,
    output logic                     out_last,
    input  logic                     f_ack
);

    localparam int N  = RATE_WORDS * 64;
    localparam int CW = $clog2(RATE_WORDS + 1);
    // Counter value when the word being inserted lands in the last slot.
    localparam logic [CW-1:0] LAST_POS = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {ABSORB, PAD, FULL, FULL_LAST} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic        accept;
    logic        at_final;
    logic [63:0] last_word;
    logic [63:0] pad_word;
    logic [63:0] ins_word;

    assign accept   = in_ready & ~buffer_full;
    assign at_final = (cnt == LAST_POS);

    // Per-byte build of the final data word: keep the valid bytes, place
    // DSBYTE right after them, zero the rest.
    for (genvar b = 0; b < 8; b++) begin : g_byte
        assign last_word[63-8*b -: 8] = (3'(b) < byte_num)  ? in[63-8*b -: 8] :
                                        (3'(b) == byte_num) ? DSBYTE : 8'h00;
    end

    always_comb begin
        pad_word = (state == PAD) ? 64'h0 : last_word;
        // The closing pad bit shares the final word, also with DSBYTE in byte 7.
        if (at_final)
            pad_word[7:0] = pad_word[7:0] | 8'h80;
        ins_word = (state == ABSORB && !is_last) ? in : pad_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ABSORB;
            cnt         <= '0;
            out         <= '0;
            buffer_full <= 1'b0;
            out_ready   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                ABSORB: begin
                    if (accept) begin
                        out <= {out[N-65:0], ins_word};
                        cnt <= cnt + CW'(1);
                        if (at_final) begin
                            state       <= is_last ? FULL_LAST : FULL;
                            buffer_full <= 1'b1;
                            out_ready   <= 1'b1;
                            out_last    <= is_last;
                        end else if (is_last) begin
                            state       <= PAD;
                            buffer_full <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    out <= {out[N-65:0], ins_word};
                    cnt <= cnt + CW'(1);
                    if (at_final) begin
                        state     <= FULL_LAST;
                        out_ready <= 1'b1;
                        out_last  <= 1'b1;
                    end
                end
                FULL, FULL_LAST: begin
                    // out is left as is; the next block shifts it out.
                    if (f_ack) begin
                        state       <= ABSORB;
                        cnt         <= '0;
                        buffer_full <= 1'b0;
                        out_ready   <= 1'b0;
                        out_last    <= 1'b0;
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end

endmodule

// File: doc/padder_rate.md
# padder_rate

Parametrised multi-rate, multi-message padder for the Keccak/SHA-3 core.
- Packs 64-bit user words into RATE_WORDS-word blocks and applies domain-separated multi-rate padding: DSBYTE after the last data byte, 0x80 in the last byte of the block.
- Presents each full block to the f_permutation module and flags the final block of each message.
- Unlike a single-shot padder, it re-arms after the final block is acknowledged, so back-to-back messages need no reset.

## Interface
- RATE_WORDS, 9, rate in 64-bit words (9=576b, 13, 17, 18, 21); legal range 2..21.
- DSBYTE, 8'h01, domain-separation byte (01 Keccak, 06 SHA3, 1F SHAKE); must be nonzero with bit 7 = 0.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- in  in  64  user word; byte 0 = in[63:56].
- in_ready  in  1  in is valid.
- is_last  in  1  qualifies in as the final word of a message; valid only with in_ready.
- byte_num  in  3  valid bytes in a last word, 0..7 (a last word is never full).
- buffer_full  out  1  block not accepting user input.
- out  out  RATE_WORDS*64  block; first word in the MSBs.
- out_ready  out  1  out holds a complete block.
- out_last  out  1  the block in out is the final block of its message; valid while out_ready = 1.
- f_ack  in  1  permutation has consumed out.

## Operation
- Accept rule: a word is accepted iff in_ready & ~buffer_full. No other input handshake exists.
- State ABSORB:
  - buffer_full = 0.
  - A non-last accepted word shifts in unchanged: out <= {out[N-65:0], word}. The word counter increments.
  - A last accepted word is modified before shifting in:
    - bytes 0..byte_num-1 are kept;
    - byte byte_num = DSBYTE;
    - remaining bytes are 0.
- Final word of the block: if an inserted word lands in position RATE_WORDS, bits [7:0] are ORed with 0x80. This applies in ABSORB and PAD, including when DSBYTE falls in byte 7 (giving DSBYTE|0x80).
- Transitions:
  - Count reaches RATE_WORDS with no last word yet -> FULL.
  - Last word accepted and count reaches RATE_WORDS -> FULL_LAST.
  - Last word accepted with count < RATE_WORDS -> PAD.
- State PAD:
  - buffer_full = 1; in and in_ready are ignored.
  - One zero word shifts in per cycle, with 0x80 in the final word.
  - Count reaches RATE_WORDS -> FULL_LAST.
- State FULL / FULL_LAST:
  - buffer_full = 1 and out_ready = 1. out_last is 0 in FULL and 1 in FULL_LAST.
  - out is held stable.
  - On f_ack, the counter clears. FULL -> ABSORB (same message continues); FULL_LAST -> ABSORB (new message).
- f_ack outside FULL/FULL_LAST is ignored.
- out is not cleared on f_ack; stale contents are shifted out by the next block.
- Counter width is clog2(RATE_WORDS+1) and it never exceeds RATE_WORDS.

## Timing
- Reset values: out = 0, out_ready = 0, out_last = 0, buffer_full = 0, counter = 0, state ABSORB.
- Reset mid-operation (any state) discards the partial block; the next message starts clean the following cycle.
- Accepted word in cycle t is visible in out at t+1.
- Block completion: if the last word is accepted at cycle t as word k, out_ready rises at t+1+(RATE_WORDS-k). For k = RATE_WORDS, that is t+1.
- f_ack at cycle t: out_ready and buffer_full fall at t+1, and input can be accepted at t+1.
- f_ack together with in_ready while full: the word is not accepted in cycle t; the user holds it.
- Throughput: one word per cycle in ABSORB; a FULL -> ABSORB turnaround costs one cycle.

## Test plan
- Empty message, default parameters (RATE_WORDS=9, DSBYTE=01):
  - Stimulus: in_ready=1, is_last=1, byte_num=0 at t0.
  - out_ready=1 and out_last=1 at t0+9.
  - out word0 = 0100000000000000, words 1..7 = 0, word8 = 0000000000000080.
- Partial last word, byte order:
  - Stimulus: in=1122334455667788, byte_num=3, is_last, as the 2nd word.
  - word1 = 1122330100000000.
  - out_ready 8 cycles after acceptance.
- Pad sharing the final word (RATE_WORDS=17, DSBYTE=06):
  - Stimulus: 16 full words, then is_last with byte_num=0.
  - out_ready the next cycle, out_last=1.
  - word16 = 0600000000000080.
- DS in byte 7 (DSBYTE=1F):
  - Stimulus: last word with byte_num=7 at block position RATE_WORDS.
  - Low byte of the final word = 9F.
- Multi-block then back-to-back messages:
  - Stimulus: 9 full words, then 1 last word (byte_num=0), then a second empty message.
  - First block: out_last=0, ack'd.
  - Second block: out_last=1, ack'd.
  - Third block: out_last=1, correct padding, no reset needed.
- Boundary events:
  - in_ready held high during PAD and during FULL: no words consumed.
  - f_ack while in ABSORB: no effect.
  - reset asserted during PAD: all outputs 0 next cycle, and a following message pads correctly.
